// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/data, hazard
// controls, downstream valid/ready/data and the occupancy count.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] inData;
    logic              Stall;
    logic              Flush;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outData;
    logic [OCC_W-1:0]  Occupancy;

    // Driver side: the stage feeding the register plus hazard/downstream control.
    modport master (
        output inValid, inData, Stall, Flush, outReady,
        input  inReady, outValid, outData, Occupancy
    );

    // The pipeline register itself.
    modport slave (
        input  inValid, inData, Stall, Flush, outReady,
        output inReady, outValid, outData, Occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Configurable pipeline-boundary register: DEPTH stages of a DATA_W bundle,
// one valid bit per stage, valid/ready handshake with bubble collapsing,
// hazard Stall (freeze) and Flush (squash). Stage 0 is the input side.
module pipe_stage_reg #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 1,
    parameter int RESET_DATA   = 1,
    parameter int ZERO_INVALID = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    pipe_stage_reg_if.slave  bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]             v_q, v_d;
    logic [DEPTH-1:0][DATA_W-1:0] d_q, d_d;
    logic [OCC_W-1:0]             occ_q, occ_d;

    // rdy[k]: stage k may load this edge; rdy[DEPTH] is the downstream sink.
    logic [DEPTH:0]               rdy;
    // What each stage would load: the previous stage, or the input for stage 0.
    logic [DEPTH-1:0]             src_v;
    logic [DEPTH-1:0][DATA_W-1:0] src_d;

    // Ready chain from the output back to the input: an empty slot or a
    // slot that is itself draining lets its predecessor move up.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = bus.outReady & ~bus.Stall;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = ~v_q[k] | rdy[k+1];
        end
    end

    // Load source for every stage.
    always_comb begin
        src_v    = '0;
        src_d    = '0;
        src_v[0] = bus.inValid;
        src_d[0] = bus.inData;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = v_q[k-1];
            src_d[k] = d_q[k-1];
        end
    end

    // Next stage state: Flush squashes everything (and beats Stall), Stall
    // freezes, otherwise every ready stage loads its source. Data only moves
    // with a valid bundle so a stage keeps its last bundle across bubbles.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (bus.Flush) begin
            v_d = '0;
            if (RESET_DATA != 0) d_d = '0;
        end else if (!bus.Stall) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v_d[k] = src_v[k];
                    if (src_v[k]) d_d[k] = src_d[k];
                end
            end
        end
    end

    // Occupancy is registered as the popcount of the next valid vector.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(v_d[k]);
        end
    end

    // State registers; synchronous reset overrides Flush and Stall.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            v_q   <= '0;
            occ_q <= '0;
            if (RESET_DATA != 0) d_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
        end
    end

    assign bus.inReady   = rdy[0] & ~bus.Stall & ~Reset;
    assign bus.outValid  = v_q[DEPTH-1];
    // Invalid output presents the all-zero NOP bundle when ZERO_INVALID is set.
    assign bus.outData   = ((ZERO_INVALID != 0) && !v_q[DEPTH-1]) ? '0 : d_q[DEPTH-1];
    assign bus.Occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a DEPTH=3 instance (zeroed invalid output, data
// not reset) and a DEPTH=1 instance (raw output, data reset), checked every
// cycle against an item-list model plus directed scenario scoreboards.
module tb_pipe_stage_reg;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    pipe_stage_reg_if #(.DATA_W(8), .DEPTH(3)) if3 ();
    pipe_stage_reg_if #(.DATA_W(8), .DEPTH(1)) if1 ();

    pipe_stage_reg #(.DATA_W(8), .DEPTH(3), .RESET_DATA(0), .ZERO_INVALID(1))
        dut3 (.Clk(Clk), .Reset(Reset), .bus(if3.slave));
    pipe_stage_reg #(.DATA_W(8), .DEPTH(1), .RESET_DATA(1), .ZERO_INVALID(0))
        dut1 (.Clk(Clk), .Reset(Reset), .bus(if1.slave));

    int errs = 0;
    int chks = 0;
    int cyc  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: per instance, a list of in-flight bundles ordered oldest first,
    // each with its slot position; bundles slide toward the output while the
    // slot ahead is (or becomes) free.
    int         mcnt [2];
    int         mpos [2][8];
    logic [7:0] mdat [2][8];
    int         mnp  [2][8];
    bit         mpop [2];
    bit         mirdy[2];
    logic [7:0] mlast[2];

    function automatic int dep(input int id);
        return (id == 0) ? 3 : 1;
    endfunction

    function automatic bit rdat(input int id);
        return id == 1;
    endfunction

    task automatic model_plan(input int id, input bit ordy, input bit stl);
        int lim;
        int first;
        mpop[id] = !stl && mcnt[id] > 0 && mpos[id][0] == dep(id) - 1 && ordy;
        first = mpop[id] ? 1 : 0;
        lim = dep(id) - 1;
        for (int i = first; i < mcnt[id]; i++) begin
            mnp[id][i] = (mpos[id][i] + 1 < lim) ? mpos[id][i] + 1 : lim;
            lim = mnp[id][i] - 1;
        end
        mirdy[id] = !stl && (mcnt[id] == first || mnp[id][mcnt[id]-1] > 0);
    endtask

    task automatic model_apply(input int id, input bit rst, input bit fl, input bit stl,
                               input bit iv, input logic [7:0] idat);
        int j;
        int first;
        int d;
        d = dep(id);
        if (rst || fl) begin
            mcnt[id] = 0;
            if (rdat(id)) mlast[id] = 8'h00;
        end else if (!stl) begin
            j = 0;
            first = mpop[id] ? 1 : 0;
            for (int i = first; i < mcnt[id]; i++) begin
                if (mnp[id][i] == d - 1 && mpos[id][i] != d - 1) mlast[id] = mdat[id][i];
                mpos[id][j] = mnp[id][i];
                mdat[id][j] = mdat[id][i];
                j++;
            end
            if (iv && mirdy[id]) begin
                mpos[id][j] = 0;
                mdat[id][j] = idat;
                if (d == 1) mlast[id] = idat;
                j++;
            end
            mcnt[id] = j;
        end
    endtask

    // Observed transfers for the directed scenarios.
    logic [7:0] obs3[$];
    int         obs3c[$];
    int         acc3c[$];
    logic [7:0] obs1[$];
    bit         acc3, acc1;

    task automatic tick(input bit do_chk);
        bit ov;
        @(negedge Clk);
        model_plan(0, if3.outReady, if3.Stall);
        model_plan(1, if1.outReady, if1.Stall);
        if (do_chk) begin
            ov = mcnt[0] > 0 && mpos[0][0] == 2;
            chk("ov3",  if3.outValid, ov);
            chk("od3",  if3.outData, ov ? mdat[0][0] : 8'h00);
            chk("ir3",  if3.inReady, !Reset && mirdy[0]);
            chk("occ3", if3.Occupancy, mcnt[0]);
            ov = mcnt[1] > 0;
            chk("ov1",  if1.outValid, ov);
            chk("od1",  if1.outData, ov ? mdat[1][0] : mlast[1]);
            chk("ir1",  if1.inReady, !Reset && mirdy[1]);
            chk("occ1", if1.Occupancy, mcnt[1]);
        end
        acc3 = if3.inValid && if3.inReady;
        acc1 = if1.inValid && if1.inReady;
        if (acc3) acc3c.push_back(cyc);
        if (if3.outValid && if3.outReady && !if3.Stall) begin
            obs3.push_back(if3.outData);
            obs3c.push_back(cyc);
        end
        if (if1.outValid && if1.outReady && !if1.Stall) obs1.push_back(if1.outData);
        model_apply(0, Reset, if3.Flush, if3.Stall, if3.inValid, if3.inData);
        model_apply(1, Reset, if1.Flush, if1.Stall, if1.inValid, if1.inData);
        cyc++;
        @(posedge Clk);
        #1;
    endtask

    task automatic push3(input logic [7:0] dat);
        int n;
        n = 0;
        if3.inValid = 1'b1;
        if3.inData  = dat;
        do begin
            tick(1);
            n++;
        end while (!acc3 && n < 12);
        chk("push3_acc", acc3, 1'b1);
        if3.inValid = 1'b0;
    endtask

    task automatic clear_obs();
        obs3.delete();
        obs3c.delete();
        acc3c.delete();
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] p1[$];

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        {if3.inValid, if3.Stall, if3.Flush, if3.outReady} = '0;
        {if1.inValid, if1.Stall, if1.Flush, if1.outReady} = '0;
        if3.inData = '0;
        if1.inData = '0;
        for (int i = 0; i < 2; i++) begin
            mcnt[i]  = 0;
            mlast[i] = 8'h00;
        end
        tick(0);
        tick(1);
        Reset = 1'b0;
        #1;
        chk("rst_ir3", if3.inReady, 1'b1);
        chk("rst_ov3", if3.outValid, 1'b0);
        chk("rst_od1", if1.outData, 8'h00);
        chk("rst_occ3", if3.Occupancy, 2'd0);

        // Fill and stream.
        clear_obs();
        if3.outReady = 1'b1;
        push3(8'h11); push3(8'h22); push3(8'h33);
        repeat (5) tick(1);
        exp_q = '{8'h11, 8'h22, 8'h33};
        chk("fs_n", obs3.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("fs_d", obs3[i], exp_q[i]);
            chk("fs_lat", obs3c[i] - acc3c[i], 3);
        end

        // Backpressure and bubble collapse.
        clear_obs();
        if3.outReady = 1'b0;
        push3(8'hA1);
        tick(1);
        push3(8'hA2); push3(8'hA3);
        if3.inValid = 1'b1;
        if3.inData  = 8'hA4;
        repeat (3) begin
            tick(1);
            chk("bp_hold", acc3, 1'b0);
            chk("bp_ir", if3.inReady, 1'b0);
            chk("bp_occ", if3.Occupancy, 2'd3);
        end
        chk("bp_noout", obs3.size(), 0);
        if3.outReady = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick(1);
            if (acc3) break;
        end
        chk("bp_a4_acc", acc3, 1'b1);
        if3.inValid = 1'b0;
        repeat (6) tick(1);
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        chk("bp_n", obs3.size(), 4);
        for (int i = 0; i < 4; i++) chk("bp_d", obs3[i], exp_q[i]);

        // Stall with two bundles in flight, the oldest at the output.
        clear_obs();
        if3.outReady = 1'b0;
        push3(8'hB1); push3(8'hB2);
        tick(1);
        if3.outReady = 1'b1;
        if3.Stall    = 1'b1;
        if3.inValid  = 1'b1;
        if3.inData   = 8'hB3;
        repeat (4) begin
            tick(1);
            chk("st_occ", if3.Occupancy, 2'd2);
            chk("st_ov", if3.outValid, 1'b1);
            chk("st_od", if3.outData, 8'hB1);
            chk("st_ir", if3.inReady, 1'b0);
        end
        chk("st_noout", obs3.size(), 0);
        if3.Stall = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick(1);
            if (acc3) break;
        end
        chk("st_b3_acc", acc3, 1'b1);
        if3.inValid = 1'b0;
        repeat (6) tick(1);
        exp_q = '{8'hB1, 8'hB2, 8'hB3};
        chk("st_n", obs3.size(), 3);
        for (int i = 0; i < 3; i++) chk("st_d", obs3[i], exp_q[i]);

        // Flush of a full pipe with a bundle offered in the same cycle.
        clear_obs();
        if3.outReady = 1'b0;
        push3(8'h01); push3(8'h02); push3(8'h03);
        if3.outReady = 1'b1;
        if3.Flush    = 1'b1;
        if3.inValid  = 1'b1;
        if3.inData   = 8'h04;
        tick(1);
        if3.Flush   = 1'b0;
        if3.inValid = 1'b0;
        chk("fl_ov", if3.outValid, 1'b0);
        chk("fl_od", if3.outData, 8'h00);
        chk("fl_occ", if3.Occupancy, 2'd0);
        repeat (5) tick(1);
        chk("fl_n", obs3.size(), 1);
        chk("fl_d", obs3[0], 8'h01);

        // Reset mid-operation overriding Flush and Stall.
        clear_obs();
        if3.outReady = 1'b0;
        push3(8'hC1); push3(8'hC2); push3(8'hC3);
        Reset = 1'b1;
        if3.Flush = 1'b1;
        if3.Stall = 1'b1;
        tick(1);
        chk("rm_occ", if3.Occupancy, 2'd0);
        chk("rm_ov", if3.outValid, 1'b0);
        chk("rm_od", if3.outData, 8'h00);
        chk("rm_ir", if3.inReady, 1'b0);
        Reset = 1'b0;
        if3.Flush = 1'b0;
        if3.Stall = 1'b0;
        #1;
        chk("rm_ir_after", if3.inReady, 1'b1);
        clear_obs();
        if3.outReady = 1'b1;
        push3(8'hD1);
        repeat (5) tick(1);
        chk("rm_n", obs3.size(), 1);
        chk("rm_d", obs3[0], 8'hD1);
        chk("rm_lat", obs3c[0] - acc3c[0], 3);

        // DEPTH=1 raw-output instance with outReady toggling every cycle.
        obs1.delete();
        for (int i = 0; i < 24; i++) p1.push_back(8'($urandom));
        begin
            int idx;
            idx = 0;
            if1.inValid = 1'b1;
            if1.inData  = p1[0];
            for (int c = 0; c < 150 && obs1.size() < 24; c++) begin
                if1.outReady = cyc[0];
                tick(1);
                if (acc1) begin
                    idx++;
                    if (idx < 24) if1.inData = p1[idx];
                    else if1.inValid = 1'b0;
                end
            end
        end
        if1.inValid  = 1'b0;
        if1.outReady = 1'b0;
        tick(1);
        chk("d1_n", obs1.size(), 24);
        for (int i = 0; i < 24; i++) chk("d1_d", obs1[i], p1[i]);
        chk("d1_ov", if1.outValid, 1'b0);
        chk("d1_ret", if1.outData, p1[23]);

        // Random traffic on both instances against the model.
        begin
            bit pend3, pend1;
            pend3 = 1'b0;
            pend1 = 1'b0;
            for (int c = 0; c < 600; c++) begin
                if (!pend3) begin
                    pend3 = 1'($urandom_range(0, 1));
                    if3.inData = 8'($urandom);
                end
                if (!pend1) begin
                    pend1 = 1'($urandom_range(0, 1));
                    if1.inData = 8'($urandom);
                end
                if3.inValid  = pend3;
                if1.inValid  = pend1;
                if3.outReady = ($urandom_range(0, 2) != 0);
                if1.outReady = ($urandom_range(0, 2) != 0);
                if3.Stall    = ($urandom_range(0, 7) == 0);
                if1.Stall    = ($urandom_range(0, 7) == 0);
                if3.Flush    = ($urandom_range(0, 31) == 0);
                if1.Flush    = ($urandom_range(0, 31) == 0);
                Reset        = ($urandom_range(0, 63) == 0);
                tick(1);
                if (acc3) pend3 = 1'b0;
                if (acc1) pend1 = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-boundary register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one configurable block.
- Carries a packed DATA_W-bit bundle through DEPTH register stages, one valid bit per stage.
- Provides a valid/ready handshake with bubble collapsing, a hazard-unit Stall (freeze) and a branch/exception Flush (squash).
- Sits between any two datapath stages; the bundle packing is done by the instantiating stage.

Parameters:
- DATA_W, 32: width of the packed control+data bundle, 1..512.
- DEPTH, 1: number of register stages, 1..8.
- RESET_DATA, 1: 1 = stage data registers reset to 0; 0 = only valid bits reset.
- ZERO_INVALID, 1: 1 = outData is forced to 0 whenever outValid=0 (the NOP bundle); 0 = raw last-stage data.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- inValid  in  1  upstream bundle valid.
- inReady  out  1  block can accept a bundle this cycle.
- inData  in  DATA_W  upstream bundle.
- Stall  in  1  hazard freeze of the whole block.
- Flush  in  1  squash all in-flight bundles.
- outValid  out  1  last stage holds a valid bundle.
- outReady  in  1  downstream accepts this cycle.
- outData  out  DATA_W  last-stage bundle.
- Occupancy  out  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Stages are indexed 0 (input side) to DEPTH-1 (output side); v[k] and d[k] are the valid bit and data of stage k.
- Ready chain, combinational: rdy[DEPTH] = outReady & ~Stall; rdy[k] = ~v[k] | rdy[k+1].
- inReady = rdy[0] & ~Stall & ~Reset.
- Advance on each posedge, when not in Reset/Flush/Stall:
  - Stage k with rdy[k]=1 loads from stage k-1: v[k] <= v[k-1], d[k] <= d[k-1].
  - Stage 0 loads v[0] <= inValid and d[0] <= inData.
  - Stage k with rdy[k]=0 holds.
  - Data of a stage loading an invalid bundle is don't-care, but must not glitch outData when ZERO_INVALID=1.
- Transfer rules:
  - Input transfer occurs iff inValid & inReady.
  - Output transfer occurs iff outValid & outReady & ~Stall.
  - inData is not sampled when inReady=0; upstream must hold inValid/inData until accepted.
- Latency and throughput:
  - Empty pipe: a bundle accepted at edge N is on outData after edge N+DEPTH-1 (DEPTH=1: visible the cycle after acceptance).
  - Sustained throughput is 1 bundle/cycle while outReady=1.
  - Bubbles collapse: with the output blocked, upstream stages keep filling empty slots until all DEPTH slots are valid; inReady then drops.
- Full: Occupancy=DEPTH and outReady=0 gives inReady=0. A full pipe with outReady=1 accepts and emits in the same cycle.
- Empty: Occupancy=0 gives outValid=0, and outData=0 if ZERO_INVALID=1.
- Stall=1:
  - No stage changes.
  - inReady=0.
  - outValid still reflects v[DEPTH-1], but no output transfer counts.
- Flush=1:
  - On the next edge all v[k] <= 0, and d[k] <= 0 if RESET_DATA=1.
  - A bundle offered at the input that cycle is discarded.
  - An output transfer occurring in the Flush cycle completes normally.
  - Flush overrides Stall.
- Reset=1:
  - On the next edge: all v[k]=0, d[k]=0 (if RESET_DATA=1), Occupancy=0, outValid=0, outData=0.
  - While Reset is high, inReady=0.
  - Reset overrides Flush and Stall.
  - Mid-stream reset discards all in-flight bundles with no partial output.
- Occupancy is registered. It equals the popcount of v after each edge and is never greater than DEPTH.
- Outputs immediately after reset: inReady=1 (once Reset is low), outValid=0, outData=0, Occupancy=0.
- Simultaneous input and output transfer on a full pipe leaves Occupancy unchanged.

Test Plan:
- Fill and stream:
  - Setup: DATA_W=8, DEPTH=3, outReady=1.
  - Stimulus: push 0x11, 0x22, 0x33 on consecutive cycles.
  - Required: outData shows 0x11, 0x22, 0x33 on cycles 3, 4, 5; outValid=1 exactly on those cycles.
- Backpressure and bubble collapse:
  - Setup: DEPTH=3, outReady=0.
  - Stimulus: push 0xA1; idle 1 cycle; push 0xA2, 0xA3, 0xA4.
  - Required: 0xA1 to 0xA3 accepted; inReady=0 with Occupancy=3 and 0xA4 held upstream.
  - Then set outReady=1: outputs 0xA1, 0xA2, 0xA3, 0xA4 in order, with no drop or duplicate.
- Stall:
  - Stimulus: with 2 bundles in flight, assert Stall for 4 cycles.
  - Required: Occupancy, outData and v frozen; inReady=0; no output transfers.
  - After release, order and latency resume unchanged.
- Flush:
  - Stimulus: pipe full (0x01, 0x02, 0x03), outReady=1, Flush plus inValid with 0x04 in the same cycle.
  - Required: 0x01 is delivered that cycle; next cycle outValid=0, outData=0, Occupancy=0; 0x04 is never output.
- Reset mid-operation:
  - Stimulus: assert Reset for 1 cycle with Flush=1, Stall=1 and a full pipe.
  - Required: next cycle all outputs are at reset values.
  - Next push after reset appears after DEPTH cycles.
- Parameter corners:
  - DEPTH=1, ZERO_INVALID=0: back-to-back push/pop at 1/cycle with outReady toggling every cycle; no loss.
  - outData retains the last bundle while outValid=0.
